ser_matrix_loader: RTL and testbench
====================================

Name: ser_matrix_loader

Overview:
Parametrised serial-to-matrix loader and successor to the fixed 4x4 serial-in matrix block. It receives a start-bit-framed serial stream on serIn, qualified by a bit strobe, and fills a ROWS x COLS bit matrix in row-major order. An optional even-parity bit follows the data bits. The matrix output L updates atomically only on a good frame. It sits between the serial input pin logic and downstream matrix consumers.

Parameters:
ROWS, 4, matrix row count (>=1)
COLS, 4, matrix column count (>=1)
PARITY_EN, 0, 1 = one even-parity bit follows the data bits; 0 = no parity bit

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  reset, synchronous, active-high
serIn  input  1  serial data line; idles high
bitEn  input  1  bit strobe; serIn is sampled only on edges where bitEn=1
L  output  [0:ROWS-1][0:COLS-1]  loaded matrix; holds last good frame
frameDone  output  1  one-cycle pulse when L takes a new frame
parErr  output  1  one-cycle pulse when a frame is rejected on parity
busy  output  1  high while a frame is in progress

Behaviour:
- Reset is synchronous: when RST=1 at an edge, L=0, frameDone=0, parErr=0, busy=0, FSM=IDLE, counter=0 and shift buffer=0. Reset has priority over all other inputs, including mid-frame.
- Bit events: nothing advances on edges where bitEn=0. A bit is accepted only when bitEn=1.
- N = ROWS*COLS. The counter is $clog2(N)-wide, minimum 1 bit.
- FSM states: IDLE, LOAD, PAR.
  - IDLE: when an accepted bit has serIn=0 (start bit), go to LOAD with count=0. An accepted bit with serIn=1 keeps IDLE. busy=0.
  - LOAD: the k-th accepted data bit (k=0..N-1) goes to buffer position [k/COLS][k%COLS]. L[0][0] is received first.
    - At k=N-1 with PARITY_EN=0: commit, then go to IDLE.
    - At k=N-1 with PARITY_EN=1: go to PAR.
  - PAR: the accepted bit is the parity bit.
    - XOR of the N data bits and the parity bit =0: commit.
    - Otherwise: reject. L is unchanged and parErr=1 for one cycle.
    - Either way, go to IDLE.
- Commit: L takes the buffer on the same edge that accepts the final bit. frameDone=1 for exactly the following cycle.
- busy=1 in LOAD and PAR. It drops on the edge that ends the frame.
- Back-to-back frames: a start bit may be accepted on the very next accepted bit after a frame ends. No idle gap is required.
- L changes only on a commit or on reset. It is never partially updated mid-frame.
- frameDone and parErr are never high together.

Decomposition:
- Shared package ser_matrix_pkg holds:
  - the state enum (IDLE, LOAD, PAR)
  - the START_BIT=1'b0 constant
  - the IDLE_LEVEL=1'b1 constant
  - a function computing the counter width.
- One sub-module, ser_shift_buf: N-bit row-major capture buffer with write-enable and index. It also keeps a running parity accumulator that clears on start.
- FSM, counter and commit logic live in ser_matrix_loader.

Test Plan:
1. Reset: RST=1 for 2 edges, serIn=0, bitEn=1 -> L=0, busy=0, frameDone=0, parErr=0. FSM stays IDLE on the next edge after RST=0 only if serIn=1.
2. Basic frame (4x4, PARITY_EN=0, bitEn=1 every cycle): send 0, then 1100 1010 0110 1111 -> busy high for 16 edges. Then frameDone pulses once, with L[0]=4'b1100, L[1]=4'b1010, L[2]=4'b0110, L[3]=4'b1111.
3. Strobe gaps: same stream with bitEn=1,0 alternating and serIn toggled junk while bitEn=0 -> identical L. frameDone arrives 16 cycles later than in scenario 2, and no bits are duplicated or lost.
4. Parity (PARITY_EN=1), same data (ten 1s):
   - parity 0 -> frameDone, L as in scenario 2.
   - next frame of all-ones data with parity 1 -> parErr pulse, no frameDone, L keeps the previous value.
5. Reset mid-frame: RST=1 after 7 data bits -> L=0, busy=0. Then the full scenario-2 frame -> correct L with no leftover bits.
6. Idle and back-to-back:
   - serIn=1 for 20 accepted bits -> no busy, no frameDone.
   - two scenario-2 frames sent with no gap, the second with data all zeros -> two frameDone pulses, final L=0.

Source files
------------

// File: rtl/ser_matrix_pkg.sv
// Shared types and constants for the serial matrix loader.
package ser_matrix_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, PAR} state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic IDLE_LEVEL = 1'b1;

   // Bit counter width for an n-bit frame; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ser_shift_buf.sv
// Row-major capture buffer with a running parity accumulator.
// Bit k of the frame lands at cap_q[N-1-k], so the vector maps directly
// onto a [0:ROWS-1][0:COLS-1] packed matrix with element [0][0] first.
module ser_shift_buf #(
   parameter int N  = 16,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          we,
   input  logic [CW-1:0] idx,
   input  logic          din,
   output logic [N-1:0]  cap_q,
   output logic [N-1:0]  cap_nxt,
   output logic          par_q
);

   // Next buffer value, exposed so the final bit can commit on its own edge.
   always_comb begin
      cap_nxt = cap_q;
      for (int k = 0; k < N; k++) begin
         if (we && (idx == CW'(k))) cap_nxt[N-1-k] = din;
      end
   end

   // Buffer and parity state; a start bit clears both for the new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q <= '0;
         par_q <= 1'b0;
      end else if (clr) begin
         cap_q <= '0;
         par_q <= 1'b0;
      end else begin
         cap_q <= cap_nxt;
         if (we) par_q <= par_q ^ din;
      end
   end

endmodule

// File: rtl/ser_matrix_loader.sv
// Start-bit-framed serial to ROWS x COLS matrix loader with optional
// even parity; L only changes on a good frame or on reset.
module ser_matrix_loader
   import ser_matrix_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int PARITY_EN = 0
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        serIn,
   input  logic                        bitEn,
   output logic [0:ROWS-1][0:COLS-1]   L,
   output logic                        frameDone,
   output logic                        parErr,
   output logic                        busy
);

   localparam int N  = ROWS * COLS;
   localparam int CW = cnt_width(N);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   cap_q;
   logic [N-1:0]   cap_nxt;
   logic           par_q;
   logic           start;
   logic           wr;

   assign start = bitEn && (state == IDLE) && (serIn == START_BIT);
   assign wr    = bitEn && (state == LOAD);

   ser_shift_buf #(.N(N), .CW(CW)) u_cap (
      .clk     (CLK),
      .rst     (RST),
      .clr     (start),
      .we      (wr),
      .idx     (cnt),
      .din     (serIn),
      .cap_q   (cap_q),
      .cap_nxt (cap_nxt),
      .par_q   (par_q)
   );

   // Frame FSM: counts data bits, checks parity and commits into L.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         L         <= '0;
         frameDone <= 1'b0;
         parErr    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frameDone <= 1'b0;
         parErr    <= 1'b0;
         if (bitEn) begin
            case (state)
               IDLE: begin
                  if (serIn == START_BIT) begin
                     state <= LOAD;
                     cnt   <= '0;
                     busy  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (cnt == CW'(N-1)) begin
                     cnt <= '0;
                     if (PARITY_EN != 0) begin
                        state <= PAR;
                     end else begin
                        // final data bit is taken from the next-value path
                        L         <= cap_nxt;
                        frameDone <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               PAR: begin
                  if ((par_q ^ serIn) == 1'b0) begin
                     L         <= cap_q;
                     frameDone <= 1'b1;
                  end else begin
                     parErr <= 1'b1;
                  end
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ser_matrix_loader.sv
// Directed bench: 4x4 loader without parity (dut0) and with parity (dut1).
module tb_ser_matrix_loader;
   import ser_matrix_pkg::*;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [1:0]       si  = 2'b11;
   logic [1:0]       be  = 2'b00;
   logic [0:3][0:3]  L0, L1;
   logic             fd0, fd1, pe0, pe1, bz0, bz1;

   int n_pass = 0;
   int n_tot  = 0;

   localparam logic [15:0] PAT = 16'hCA6F; // rows 1100 1010 0110 1111

   always #5 CLK = ~CLK;

   ser_matrix_loader #(.ROWS(4), .COLS(4), .PARITY_EN(0)) dut0 (
      .CLK(CLK), .RST(RST), .serIn(si[0]), .bitEn(be[0]),
      .L(L0), .frameDone(fd0), .parErr(pe0), .busy(bz0));

   ser_matrix_loader #(.ROWS(4), .COLS(4), .PARITY_EN(1)) dut1 (
      .CLK(CLK), .RST(RST), .serIn(si[1]), .bitEn(be[1]),
      .L(L1), .frameDone(fd1), .parErr(pe1), .busy(bz1));

   // Drive one DUT's inputs for one edge (the other DUT sees no strobe).
   task automatic drive(input int p, input logic v, input logic en);
      be = 2'b00;
      si[p] = v;
      be[p] = en;
      @(posedge CLK);
      #1;
   endtask

   // Send start + 16 data bits (+ parity), optionally with a dead cycle
   // after each accepted bit, and collect output activity per edge.
   task automatic send_frame(input int p, input logic [15:0] d, input bit gaps,
                             input bit with_par, input logic parbit, input bit tail,
                             output int fd_edge, output int fd_cnt,
                             output int pe_cnt, output int busy_cnt);
      int   e, nb;
      logic v;
      e = 0; fd_edge = 0; fd_cnt = 0; pe_cnt = 0; busy_cnt = 0;
      nb = with_par ? 18 : 17;
      for (int i = 0; i < nb; i++) begin
         v = (i == 0) ? START_BIT : (i <= 16) ? d[16-i] : parbit;
         drive(p, v, 1'b1);
         e++;
         if ((p == 0 ? fd0 : fd1) === 1'b1) begin fd_cnt++; if (fd_edge == 0) fd_edge = e; end
         if ((p == 0 ? pe0 : pe1) === 1'b1) pe_cnt++;
         if ((p == 0 ? bz0 : bz1) === 1'b1) busy_cnt++;
         if (gaps && i != nb - 1) begin
            drive(p, ~v, 1'b0);
            e++;
            if ((p == 0 ? fd0 : fd1) === 1'b1) begin fd_cnt++; if (fd_edge == 0) fd_edge = e; end
            if ((p == 0 ? pe0 : pe1) === 1'b1) pe_cnt++;
            if ((p == 0 ? bz0 : bz1) === 1'b1) busy_cnt++;
         end
      end
      if (tail) begin
         drive(p, IDLE_LEVEL, 1'b0);
         if ((p == 0 ? fd0 : fd1) === 1'b1) fd_cnt++;
         if ((p == 0 ? pe0 : pe1) === 1'b1) pe_cnt++;
         if ((p == 0 ? bz0 : bz1) === 1'b1) busy_cnt++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      drive(0, 1'b0, 1'b1);
      drive(0, 1'b0, 1'b1);
      n_tot++; if (L0 !== 16'h0)   $display("FAIL reset_L0 got %h want 0000", L0); else n_pass++;
      n_tot++; if (bz0 !== 1'b0)   $display("FAIL reset_busy0 got %b want 0", bz0); else n_pass++;
      n_tot++; if (fd0 !== 1'b0)   $display("FAIL reset_fd0 got %b want 0", fd0); else n_pass++;
      n_tot++; if (pe0 !== 1'b0)   $display("FAIL reset_pe0 got %b want 0", pe0); else n_pass++;
      n_tot++; if (L1 !== 16'h0)   $display("FAIL reset_L1 got %h want 0000", L1); else n_pass++;
      n_tot++; if (bz1 !== 1'b0)   $display("FAIL reset_busy1 got %b want 0", bz1); else n_pass++;
      RST = 1'b0;
      drive(0, IDLE_LEVEL, 1'b1);
      n_tot++; if (bz0 !== 1'b0)   $display("FAIL reset_idle_hold got %b want 0", bz0); else n_pass++;
   endtask

   task automatic test_basic();
      int fe, fc, pc, bc;
      send_frame(0, PAT, 1'b0, 1'b0, 1'b0, 1'b1, fe, fc, pc, bc);
      n_tot++; if (L0 !== PAT)  $display("FAIL basic_L got %h want %h", L0, PAT); else n_pass++;
      n_tot++; if (fe !== 17)   $display("FAIL basic_fd_edge got %0d want 17", fe); else n_pass++;
      n_tot++; if (fc !== 1)    $display("FAIL basic_fd_count got %0d want 1", fc); else n_pass++;
      n_tot++; if (bc !== 16)   $display("FAIL basic_busy_cycles got %0d want 16", bc); else n_pass++;
      n_tot++; if (pc !== 0)    $display("FAIL basic_parerr got %0d want 0", pc); else n_pass++;
   endtask

   task automatic test_strobe_gaps();
      int fe, fc, pc, bc;
      RST = 1'b1; drive(0, IDLE_LEVEL, 1'b0); RST = 1'b0;
      send_frame(0, PAT, 1'b1, 1'b0, 1'b0, 1'b1, fe, fc, pc, bc);
      n_tot++; if (L0 !== PAT)  $display("FAIL gaps_L got %h want %h", L0, PAT); else n_pass++;
      n_tot++; if (fe !== 33)   $display("FAIL gaps_fd_edge got %0d want 33", fe); else n_pass++;
      n_tot++; if (fc !== 1)    $display("FAIL gaps_fd_count got %0d want 1", fc); else n_pass++;
      n_tot++; if (bc !== 32)   $display("FAIL gaps_busy_cycles got %0d want 32", bc); else n_pass++;
   endtask

   task automatic test_parity();
      int fe, fc, pc, bc;
      send_frame(1, PAT, 1'b0, 1'b1, 1'b0, 1'b1, fe, fc, pc, bc);
      n_tot++; if (L1 !== PAT)  $display("FAIL par_good_L got %h want %h", L1, PAT); else n_pass++;
      n_tot++; if (fe !== 18)   $display("FAIL par_good_fd_edge got %0d want 18", fe); else n_pass++;
      n_tot++; if (pc !== 0)    $display("FAIL par_good_parerr got %0d want 0", pc); else n_pass++;
      n_tot++; if (bc !== 17)   $display("FAIL par_good_busy got %0d want 17", bc); else n_pass++;
      send_frame(1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, fe, fc, pc, bc);
      n_tot++; if (pc !== 1)    $display("FAIL par_bad_parerr got %0d want 1", pc); else n_pass++;
      n_tot++; if (fc !== 0)    $display("FAIL par_bad_fd got %0d want 0", fc); else n_pass++;
      n_tot++; if (L1 !== PAT)  $display("FAIL par_bad_L_hold got %h want %h", L1, PAT); else n_pass++;
      n_tot++; if (L0 !== PAT)  $display("FAIL par_other_dut_L got %h want %h", L0, PAT); else n_pass++;
   endtask

   task automatic test_mid_reset();
      int fe, fc, pc, bc;
      drive(0, START_BIT, 1'b1);
      for (int i = 0; i < 7; i++) drive(0, 1'b1, 1'b1);
      n_tot++; if (bz0 !== 1'b1)  $display("FAIL midrst_busy_before got %b want 1", bz0); else n_pass++;
      RST = 1'b1;
      drive(0, 1'b1, 1'b1);
      RST = 1'b0;
      n_tot++; if (L0 !== 16'h0)  $display("FAIL midrst_L got %h want 0000", L0); else n_pass++;
      n_tot++; if (bz0 !== 1'b0)  $display("FAIL midrst_busy got %b want 0", bz0); else n_pass++;
      send_frame(0, PAT, 1'b0, 1'b0, 1'b0, 1'b1, fe, fc, pc, bc);
      n_tot++; if (L0 !== PAT)    $display("FAIL midrst_reload_L got %h want %h", L0, PAT); else n_pass++;
      n_tot++; if (fe !== 17)     $display("FAIL midrst_fd_edge got %0d want 17", fe); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int fe, fc, pc, bc, nb, nf;
      nb = 0; nf = 0;
      for (int i = 0; i < 20; i++) begin
         drive(0, IDLE_LEVEL, 1'b1);
         if (bz0 === 1'b1) nb++;
         if (fd0 === 1'b1) nf++;
      end
      n_tot++; if (nb !== 0) $display("FAIL idle_busy got %0d want 0", nb); else n_pass++;
      n_tot++; if (nf !== 0) $display("FAIL idle_fd got %0d want 0", nf); else n_pass++;
      send_frame(0, PAT, 1'b0, 1'b0, 1'b0, 1'b0, fe, fc, pc, bc);
      n_tot++; if (fc !== 1) $display("FAIL b2b_first_fd got %0d want 1", fc); else n_pass++;
      send_frame(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, fe, fc, pc, bc);
      n_tot++; if (fc !== 1)      $display("FAIL b2b_second_fd got %0d want 1", fc); else n_pass++;
      n_tot++; if (fe !== 17)     $display("FAIL b2b_second_fd_edge got %0d want 17", fe); else n_pass++;
      n_tot++; if (L0 !== 16'h0)  $display("FAIL b2b_final_L got %h want 0000", L0); else n_pass++;
   endtask

   // Never let both pulses be high together on either instance.
   always @(negedge CLK) begin
      if (!RST && ((fd0 && pe0) || (fd1 && pe1))) begin
         n_tot++;
         $display("FAIL pulse_exclusive fd0=%b pe0=%b fd1=%b pe1=%b want not both", fd0, pe0, fd1, pe1);
      end
   end

   initial begin
      test_reset();
      test_basic();
      test_strobe_gaps();
      test_parity();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
